iob_cache_line_fill: RTL

Line-fill assembler sitting directly downstream of the cache read channel. It collects the back-end words of a refill (`read_valid`/`read_addr`/`read_rdata`) into a full-line buffer. It forwards the critical word to the front-end as soon as it arrives. Once every word of the line is present, it commits the line to the data memory and the tag/valid update to the tag memory in a single cycle.

---
 rtl/iob_cache_line_fill_pkg.sv | 33 +++
 rtl/iob_cache_line_fill.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/iob_cache_line_fill_pkg.sv
// Shared types, state encoding and width helpers for the cache line-fill assembler.
package iob_cache_line_fill_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  typedef enum logic [1:0] {
    StIdle   = IDLE,
    StFill   = FILL,
    StCommit = COMMIT
  } state_e;

  localparam int unsigned DEF_BE_DATA_W = 32;
  localparam int unsigned DEF_LINE2BE_W = 2;
  localparam int unsigned DEF_TAG_W     = 16;
  localparam int unsigned DEF_INDEX_W   = 7;
  localparam int unsigned DEF_NWAYS_W   = 1;

  // Zero-width fields (one-word line, direct-mapped) still need a 1-bit port.
  function automatic int unsigned clamp_w(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int unsigned line_w(input int unsigned be_w, input int unsigned l2be_w);
    return be_w << l2be_w;
  endfunction

  localparam int unsigned LINE_W = line_w(DEF_BE_DATA_W, DEF_LINE2BE_W);
  localparam int unsigned OFF_W  = clamp_w(DEF_LINE2BE_W);
  localparam int unsigned WAY_W  = clamp_w(DEF_NWAYS_W);

endpackage

// File: rtl/iob_cache_line_fill.sv
// Line-fill assembler: gathers back-end words of a refill, forwards the critical word,
// then commits the whole line and its tag in one cycle.
module iob_cache_line_fill
  import iob_cache_line_fill_pkg::*;
#(
  parameter int unsigned BE_DATA_W = DEF_BE_DATA_W,
  parameter int unsigned LINE2BE_W = DEF_LINE2BE_W,
  parameter int unsigned TAG_W     = DEF_TAG_W,
  parameter int unsigned INDEX_W   = DEF_INDEX_W,
  parameter int unsigned NWAYS_W   = DEF_NWAYS_W
) (
  input  logic                                       clk_i,
  input  logic                                       reset,
  input  logic                                       fill_start_i,
  input  logic [TAG_W-1:0]                           fill_tag_i,
  input  logic [INDEX_W-1:0]                         fill_index_i,
  input  logic [clamp_w(NWAYS_W)-1:0]                fill_way_i,
  input  logic [clamp_w(LINE2BE_W)-1:0]              fill_crit_i,
  input  logic                                       read_valid_i,
  input  logic [clamp_w(LINE2BE_W)-1:0]              read_addr_i,
  input  logic [BE_DATA_W-1:0]                       read_rdata_i,
  output logic                                       line_we_o,
  output logic [INDEX_W-1:0]                         line_index_o,
  output logic [clamp_w(NWAYS_W)-1:0]                line_way_o,
  output logic [line_w(BE_DATA_W, LINE2BE_W)-1:0]    line_wdata_o,
  output logic                                       tag_we_o,
  output logic [TAG_W-1:0]                           tag_o,
  output logic                                       crit_valid_o,
  output logic [BE_DATA_W-1:0]                       crit_rdata_o,
  output logic                                       busy_o,
  output logic                                       done_o,
  output logic                                       err_o
);

  localparam int unsigned OffW   = clamp_w(LINE2BE_W);
  localparam int unsigned WayW   = clamp_w(NWAYS_W);
  localparam int unsigned LineW  = line_w(BE_DATA_W, LINE2BE_W);
  localparam int unsigned NWords = 1 << LINE2BE_W;

  state_e state_q, state_d;

  logic [TAG_W-1:0]     tag_q;
  logic [INDEX_W-1:0]   index_q;
  logic [WayW-1:0]      way_q;
  logic [OffW-1:0]      crit_q;
  logic [NWords-1:0]    mask_q;
  logic [LineW-1:0]     line_q;
  logic                 crit_valid_q;
  logic [BE_DATA_W-1:0] crit_rdata_q;
  logic                 line_we_q;
  logic                 tag_we_q;
  logic                 done_q;
  logic                 err_q;

  logic [OffW-1:0]   slot;
  logic [OffW-1:0]   crit_eff;
  logic [NWords-1:0] slot_oh;
  logic [NWords-1:0] mask_new;
  logic              word_acc;
  logic              word_dup;
  logic              word_crit;
  logic              line_full;

  // With a one-word line the offsets carry no information and are forced to zero.
  assign slot      = (LINE2BE_W == 0) ? '0 : read_addr_i;
  assign crit_eff  = (LINE2BE_W == 0) ? '0 : crit_q;
  assign slot_oh   = NWords'(1) << slot;
  assign word_acc  = read_valid_i && (state_q == StFill);
  assign word_dup  = |(mask_q & slot_oh);
  assign word_crit = word_acc && !word_dup && (slot == crit_eff);
  assign mask_new  = mask_q | slot_oh;
  assign line_full = &mask_new;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (fill_start_i) state_d = StFill;
      StFill:   if (word_acc && line_full) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q      <= StIdle;
      tag_q        <= '0;
      index_q      <= '0;
      way_q        <= '0;
      crit_q       <= '0;
      mask_q       <= '0;
      line_q       <= '0;
      crit_valid_q <= 1'b0;
      crit_rdata_q <= '0;
      line_we_q    <= 1'b0;
      tag_we_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      crit_valid_q <= 1'b0;
      line_we_q    <= 1'b0;
      tag_we_q     <= 1'b0;
      done_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fill_start_i) begin
            tag_q   <= fill_tag_i;
            index_q <= fill_index_i;
            way_q   <= fill_way_i;
            crit_q  <= fill_crit_i;
            mask_q  <= '0;
            err_q   <= 1'b0;
          end
          // A stray word is an error even if a refill is launched in the same cycle.
          if (read_valid_i) err_q <= 1'b1;
        end
        StFill: begin
          if (fill_start_i) err_q <= 1'b1;
          if (word_acc) begin
            for (int unsigned k = 0; k < NWords; k++) begin
              if (slot_oh[k]) line_q[k*BE_DATA_W +: BE_DATA_W] <= read_rdata_i;
            end
            mask_q <= mask_new;
            if (word_dup) err_q <= 1'b1;
            if (word_crit) begin
              crit_valid_q <= 1'b1;
              crit_rdata_q <= read_rdata_i;
            end
            if (line_full) begin
              line_we_q <= 1'b1;
              tag_we_q  <= 1'b1;
              done_q    <= 1'b1;
            end
          end
        end
        StCommit: begin
          if (read_valid_i || fill_start_i) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign line_we_o    = line_we_q;
  assign line_index_o = index_q;
  assign line_way_o   = way_q;
  assign line_wdata_o = line_q;
  assign tag_we_o     = tag_we_q;
  assign tag_o        = tag_q;
  assign crit_valid_o = crit_valid_q;
  assign crit_rdata_o = crit_rdata_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
